peripheral_timer_multi: RTL and testbench
=========================================

PERIPHERAL_TIMER_MULTI -- requirements
Module: peripheral_timer_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent timer channels (legal 1..4).
REQ-002 SHALL have parameter WIDTH, default 16, counter/load width in bits (legal 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cs  input  1  chip select; bus access ignored when 0.
REQ-006 SHALL have port rd  input  1  read strobe, qualified by cs.
REQ-007 SHALL have port wr  input  1  write strobe, qualified by cs.
REQ-008 SHALL have port addr  input  4  register address: addr[3:2] channel, addr[1:0] register.
REQ-009 SHALL have port data_in  input  16  write data.
REQ-010 SHALL have port data_out  output  16  registered read data.
REQ-011 SHALL have port irq  output  CHANNELS  per-channel interrupt, level.

Function
REQ-012 SHALL provide per-channel registers: 0 CTRL (RW), 1 LOAD (RW), 2 COUNT (RO), 3 STATUS (W1C).
REQ-013 SHALL define CTRL bits: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE, [15:8] PRESCALE; other bits read 0.
REQ-014 SHALL store LOAD and COUNT as WIDTH bits; reads zero-extend, writes ignore data_in[15:WIDTH].
REQ-015 SHALL define STATUS bit [0] DONE; writing 1 clears it, writing 0 has no effect.
REQ-016 SHALL perform a write on the clock edge where cs=1 and wr=1; wr takes precedence if rd is also 1.
REQ-017 SHALL update data_out one cycle after cs=1, rd=1, wr=0 with the addressed register value; data_out holds its value otherwise.
REQ-018 SHALL return 0 for reads of a channel index >= CHANNELS; writes to such addresses SHALL have no effect.
REQ-019 SHALL, on a LOAD write, load the new value into both LOAD and COUNT in the same edge.
REQ-020 SHALL generate a channel tick every PRESCALE+1 clocks while EN=1; the prescaler SHALL clear whenever EN is 0 or a CTRL write sets EN from 0 to 1.
REQ-021 SHALL decrement COUNT by 1 on each tick when COUNT != 0.
REQ-022 SHALL, on a tick with COUNT == 0, set DONE, and SHALL either reload COUNT from LOAD (periodic) or clear EN and hold COUNT at 0 (one-shot).
REQ-023 SHALL treat LOAD=0 in periodic mode as an expiry on every tick.
REQ-024 SHALL give DONE-set priority over a simultaneous STATUS W1C on the same edge.
REQ-025 SHALL give a bus LOAD write priority over a simultaneous decrement or reload of COUNT.
REQ-026 SHALL drive irq[c] = DONE[c] AND IE[c] from registered state (no combinational path from bus inputs).
REQ-027 SHALL keep channels fully independent; an access to one channel SHALL NOT alter another channel's state.

Reset
REQ-028 SHALL, while rst=0, asynchronously force CTRL, LOAD, COUNT, DONE, prescalers, data_out and irq to 0.
REQ-029 SHALL abort any in-progress count on reset; no DONE SHALL result from a count interrupted by reset.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Verification
REQ-031 Reset: set channel 0 running, then pulse rst=0 for 1 cycle mid-count -> all registers read 0, irq=0, counting stopped.
REQ-032 Periodic: LOAD=3, CTRL=0x0007 (PRESCALE=0) -> COUNT sequence 3,2,1,0,3...; DONE and irq[0] assert 4 clocks after enable and every 4 clocks thereafter until cleared.
REQ-033 One-shot with prescale: LOAD=2, CTRL=0x0105 (PRESCALE=1, one-shot) -> DONE after 6 clocks; CTRL reads 0x0104 (EN cleared); COUNT holds 0.
REQ-034 W1C race: periodic LOAD=0, write STATUS=1 on an expiry edge -> DONE remains 1; a W1C on a non-expiry edge clears it.
REQ-035 Isolation/width: WIDTH=8, write LOAD=0x1FF to channel 1 -> reads 0x00FF; channel 0 registers unchanged; read of addr 0xC (channel 3) returns 0.
REQ-036 Read latency: rd with cs=1 to COUNT -> data_out valid exactly one clock later; with cs=0 data_out unchanged.

Source files
------------

// File: rtl/peripheral_timer_multi.sv
// Multi-channel down-counting timer with per-channel prescaler, one-shot/periodic modes
// and W1C done status, accessed through a simple chip-select register bus.
module peripheral_timer_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                rd,
    input  logic                wr,
    input  logic [3:0]          addr,
    input  logic [15:0]         data_in,
    output logic [15:0]         data_out,
    output logic [CHANNELS-1:0] irq
);

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegLoad   = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] ie_q, ie_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [7:0]          prescale_q [CHANNELS];
    logic [7:0]          prescale_d [CHANNELS];
    logic [7:0]          presc_q    [CHANNELS];
    logic [7:0]          presc_d    [CHANNELS];
    logic [WIDTH-1:0]    load_q     [CHANNELS];
    logic [WIDTH-1:0]    load_d     [CHANNELS];
    logic [WIDTH-1:0]    count_q    [CHANNELS];
    logic [WIDTH-1:0]    count_d    [CHANNELS];

    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] expire;
    logic [1:0]          ch_sel;
    logic [1:0]          reg_sel;
    logic                bus_wr;
    logic                bus_rd;
    logic [15:0]         rdata;
    logic                unused_data_bits;

    assign ch_sel  = addr[3:2];
    assign reg_sel = addr[1:0];
    assign bus_wr  = cs & wr;
    assign bus_rd  = cs & rd & ~wr;

    // CTRL bits [7:3] are reserved and never stored.
    assign unused_data_bits = ^data_in[7:3];

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        ie_d   = ie_q;
        done_d = done_q;
        tick   = '0;
        expire = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            prescale_d[c] = prescale_q[c];
            presc_d[c]    = presc_q[c];
            load_d[c]     = load_q[c];
            count_d[c]    = count_q[c];

            // >= keeps ticking if PRESCALE is lowered below the running prescaler value.
            tick[c]   = en_q[c] && (presc_q[c] >= prescale_q[c]);
            expire[c] = tick[c] && (count_q[c] == '0);

            if (!en_q[c] || tick[c]) begin
                presc_d[c] = '0;
            end else begin
                presc_d[c] = presc_q[c] + 8'd1;
            end

            if (tick[c]) begin
                if (expire[c]) begin
                    done_d[c] = 1'b1;
                    if (mode_q[c]) begin
                        count_d[c] = load_q[c];
                    end else begin
                        en_d[c] = 1'b0;
                    end
                end else begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end
            end

            // Bus writes land after the timer update so they win over decrement/reload.
            if (bus_wr && (ch_sel == 2'(c))) begin
                unique case (reg_sel)
                    RegCtrl: begin
                        en_d[c]       = data_in[0];
                        mode_d[c]     = data_in[1];
                        ie_d[c]       = data_in[2];
                        prescale_d[c] = data_in[15:8];
                    end
                    RegLoad: begin
                        load_d[c]  = data_in[WIDTH-1:0];
                        count_d[c] = data_in[WIDTH-1:0];
                    end
                    RegCount: begin
                    end
                    RegStatus: begin
                        if (data_in[0] && !expire[c]) begin
                            done_d[c] = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (ch_sel == 2'(c)) begin
                unique case (reg_sel)
                    RegCtrl:   rdata = {prescale_q[c], 5'b0, ie_q[c], mode_q[c], en_q[c]};
                    RegLoad:   rdata[WIDTH-1:0] = load_q[c];
                    RegCount:  rdata[WIDTH-1:0] = count_q[c];
                    RegStatus: rdata[0] = done_q[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= '0;
            mode_q   <= '0;
            ie_q     <= '0;
            done_q   <= '0;
            data_out <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                prescale_q[c] <= '0;
                presc_q[c]    <= '0;
                load_q[c]     <= '0;
                count_q[c]    <= '0;
            end
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                prescale_q[c] <= prescale_d[c];
                presc_q[c]    <= presc_d[c];
                load_q[c]     <= load_d[c];
                count_q[c]    <= count_d[c];
            end
            if (bus_rd) begin
                data_out <= rdata;
            end
        end
    end

    assign irq = done_q & ie_q;

endmodule

// File: tb/tb_peripheral_timer_multi.sv
// Directed bench for peripheral_timer_multi: a per-edge behavioural model is compared every
// cycle, plus hand-computed expectations at the interesting points of each scenario.
module tb_peripheral_timer_multi;

    localparam int NCH = 2;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cs = 1'b0;
    logic           rd = 1'b0;
    logic           wr = 1'b0;
    logic [3:0]     addr = 4'h0;
    logic [15:0]    data_in = 16'h0;
    logic [15:0]    data_out;
    logic [NCH-1:0] irq;

    int n_checks = 0;
    int n_pass   = 0;

    peripheral_timer_multi #(
        .CHANNELS(NCH),
        .WIDTH   (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: channel state plus "clocks left until next tick".
    bit          m_en    [NCH];
    bit          m_mode  [NCH];
    bit          m_ie    [NCH];
    bit          m_done  [NCH];
    int          m_ps    [NCH];
    int          m_load  [NCH];
    int          m_count [NCH];
    int          m_left  [NCH];
    logic [15:0] m_dout;
    bit          t_tick;
    bit          t_exp;
    bit          t_old_en;
    int          t_ch;

    function automatic logic [15:0] reg_value(input int ch, input int r);
        if (ch >= NCH) return 16'h0;
        case (r)
            0:       return 16'(m_ps[ch] * 256 + (m_ie[ch] ? 4 : 0) + (m_mode[ch] ? 2 : 0)
                            + (m_en[ch] ? 1 : 0));
            1:       return 16'(m_load[ch]);
            2:       return 16'(m_count[ch]);
            default: return m_done[ch] ? 16'h1 : 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] model_irq();
        logic [15:0] v;
        v = 16'h0;
        for (int c = 0; c < NCH; c++) if (m_done[c] && m_ie[c]) v[c] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_done[c] = 0;
                m_ps[c] = 0; m_load[c] = 0; m_count[c] = 0; m_left[c] = 0;
            end
            m_dout = 16'h0;
        end else begin
            t_ch = int'(addr[3:2]);
            if (cs && rd && !wr) m_dout = reg_value(t_ch, int'(addr[1:0]));
            for (int c = 0; c < NCH; c++) begin
                t_old_en = m_en[c];
                t_tick   = 0;
                if (m_en[c]) begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) begin
                        t_tick    = 1;
                        m_left[c] = m_ps[c] + 1;
                    end
                end
                t_exp = t_tick && (m_count[c] == 0);
                if (t_tick) begin
                    if (m_count[c] == 0) begin
                        m_done[c] = 1;
                        if (m_mode[c]) m_count[c] = m_load[c];
                        else m_en[c] = 0;
                    end else begin
                        m_count[c] = m_count[c] - 1;
                    end
                end
                if (cs && wr && t_ch == c) begin
                    case (addr[1:0])
                        2'd0: begin
                            m_en[c]   = data_in[0];
                            m_mode[c] = data_in[1];
                            m_ie[c]   = data_in[2];
                            m_ps[c]   = int'(data_in[15:8]);
                            if (!t_old_en && data_in[0]) m_left[c] = m_ps[c] + 1;
                        end
                        2'd1: begin
                            m_load[c]  = int'(data_in[W-1:0]);
                            m_count[c] = m_load[c];
                        end
                        2'd3: if (data_in[0] && !t_exp) m_done[c] = 0;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cycle_data_out", data_out, m_dout);
        check("cycle_irq", 16'(irq), model_irq());
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [15:0] exp, input string name);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
        check(name, data_out, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_data_out", data_out, 16'h0);
        check("reset_irq", 16'(irq), 16'h0);

        // Reset mid-count
        wr_reg(4'h1, 16'h0005);
        wr_reg(4'h0, 16'h0001);
        idle(2);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        check("rst_pulse_irq", 16'(irq), 16'h0);
        rd_reg(4'h0, 16'h0000, "rst_ctrl");
        rd_reg(4'h1, 16'h0000, "rst_load");
        rd_reg(4'h2, 16'h0000, "rst_count");
        rd_reg(4'h3, 16'h0000, "rst_status");
        idle(8);
        rd_reg(4'h2, 16'h0000, "rst_count_stopped");
        rd_reg(4'h3, 16'h0000, "rst_no_done");

        // Periodic, LOAD=3, PRESCALE=0: expiry every 4th edge after enable
        wr_reg(4'h1, 16'h0003);
        wr_reg(4'h0, 16'h0007);
        idle(3);
        check("per_irq_before", 16'(irq), 16'h0);
        idle(1);
        check("per_irq_4clk", 16'(irq), 16'h1);
        rd_reg(4'h2, 16'h0003, "per_count_reload");
        rd_reg(4'h2, 16'h0002, "per_count_dec");
        wr_reg(4'h3, 16'h0001);
        check("per_w1c_clear", 16'(irq), 16'h0);
        idle(1);
        check("per_irq_again", 16'(irq), 16'h1);
        rd_reg(4'h2, 16'h0003, "per_count_wrap");
        wr_reg(4'h0, 16'h0000);
        wr_reg(4'h3, 16'h0001);
        check("per_stopped_irq", 16'(irq), 16'h0);

        // One-shot, LOAD=2, PRESCALE=1: expiry after 6 clocks
        wr_reg(4'h1, 16'h0002);
        wr_reg(4'h0, 16'h0105);
        idle(5);
        check("os_irq_before", 16'(irq), 16'h0);
        idle(1);
        check("os_irq_6clk", 16'(irq), 16'h1);
        rd_reg(4'h0, 16'h0104, "os_ctrl_en_cleared");
        rd_reg(4'h2, 16'h0000, "os_count_zero");
        idle(4);
        rd_reg(4'h2, 16'h0000, "os_count_holds");
        rd_reg(4'h3, 16'h0001, "os_done");
        wr_reg(4'h3, 16'h0001);
        check("os_cleared_irq", 16'(irq), 16'h0);

        // W1C race, periodic LOAD=0, PRESCALE=1: expiries on even edges after enable
        wr_reg(4'h1, 16'h0000);
        wr_reg(4'h0, 16'h0103);
        idle(1);
        wr_reg(4'h3, 16'h0001);
        rd_reg(4'h3, 16'h0001, "race_done_kept");
        idle(1);
        wr_reg(4'h3, 16'h0001);
        rd_reg(4'h3, 16'h0000, "race_w1c_clears");
        wr_reg(4'h0, 16'h0000);
        wr_reg(4'h3, 16'h0001);

        // Isolation and width truncation
        wr_reg(4'h1, 16'h005A);
        wr_reg(4'h0, 16'h0302);
        wr_reg(4'h5, 16'h01FF);
        rd_reg(4'h5, 16'h00FF, "iso_ch1_load");
        rd_reg(4'h6, 16'h00FF, "iso_ch1_count");
        rd_reg(4'h1, 16'h005A, "iso_ch0_load");
        rd_reg(4'h0, 16'h0302, "iso_ch0_ctrl");
        rd_reg(4'h2, 16'h005A, "iso_ch0_count");
        rd_reg(4'h3, 16'h0000, "iso_ch0_status");
        rd_reg(4'hC, 16'h0000, "iso_ch3_ctrl");
        wr_reg(4'hD, 16'h1234);
        rd_reg(4'hD, 16'h0000, "iso_ch3_load");
        rd_reg(4'h8, 16'h0000, "iso_ch2_ctrl");

        // Read latency and cs qualification
        rd_reg(4'h6, 16'h00FF, "lat_prev");
        rd = 1'b1; addr = 4'h1;
        idle(3);
        check("lat_cs0_hold", data_out, 16'h00FF);
        cs = 1'b1;
        @(negedge clk);
        check("lat_before_edge", data_out, 16'h00FF);
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0;
        check("lat_after_edge", data_out, 16'h005A);

        // Write wins over a simultaneous read
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'h5; data_in = 16'h0033;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        check("wr_over_rd_dout", data_out, 16'h005A);
        rd_reg(4'h5, 16'h0033, "wr_over_rd_load");

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
